// File: rtl/tcdm_bank_responder.sv
// rtl/tcdm_bank_responder.sv - TCDM bank endpoint: SRAM driver, AMO/LR-SC engine, response buffer
//
// Purpose: accepts slave requests for one single-port SRAM bank, performs plain
// reads/writes, atomic read-modify-write operations and LR/SC, and returns
// responses that echo the request metadata through a small fall-through buffer.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   req_*                  slave request (valid/ready, addr, wen, be, data, amo, tags)
//   resp_*                 slave response (valid/ready, data, echoed amo and tags)
//   mem_*                  SRAM interface; mem_rdata_i valid one cycle after a read
module tcdm_bank_responder #(
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned BankAddrWidth = 8,
  parameter int unsigned MetaIdWidth   = 6,
  parameter int unsigned CoreIdWidth   = 2,
  parameter int unsigned IniAddrWidth  = 4,
  parameter int unsigned RespDepth     = 2,
  parameter bit          LrScEnable    = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [BankAddrWidth-1:0] req_addr_i,
  input  logic                     req_wen_i,
  input  logic [DataWidth/8-1:0]   req_be_i,
  input  logic [DataWidth-1:0]     req_data_i,
  input  logic [3:0]               req_amo_i,
  input  logic [MetaIdWidth-1:0]   req_meta_id_i,
  input  logic [CoreIdWidth-1:0]   req_core_id_i,
  input  logic [IniAddrWidth-1:0]  req_ini_addr_i,
  output logic                     resp_valid_o,
  input  logic                     resp_ready_i,
  output logic [DataWidth-1:0]     resp_data_o,
  output logic [3:0]               resp_amo_o,
  output logic [MetaIdWidth-1:0]   resp_meta_id_o,
  output logic [CoreIdWidth-1:0]   resp_core_id_o,
  output logic [IniAddrWidth-1:0]  resp_ini_addr_o,
  output logic                     mem_req_o,
  output logic                     mem_we_o,
  output logic [BankAddrWidth-1:0] mem_addr_o,
  output logic [DataWidth/8-1:0]   mem_be_o,
  output logic [DataWidth-1:0]     mem_wdata_o,
  input  logic [DataWidth-1:0]     mem_rdata_i
);

  localparam int unsigned CntWidth = $clog2(RespDepth + 1);
  localparam int unsigned PtrWidth = (RespDepth > 1) ? $clog2(RespDepth) : 1;

  typedef enum logic [0:0] {IDLE, AMO_WB} state_e;

  typedef struct packed {
    logic [DataWidth-1:0]    data;
    logic [3:0]              amo;
    logic [MetaIdWidth-1:0]  meta_id;
    logic [CoreIdWidth-1:0]  core_id;
    logic [IniAddrWidth-1:0] ini_addr;
  } resp_t;

  state_e                  state_q, state_d;
  logic                    pend_q, pend_sc_q, pend_sc_fail_q;
  logic [3:0]              meta_amo_q;
  logic [MetaIdWidth-1:0]  meta_id_q;
  logic [CoreIdWidth-1:0]  meta_core_q;
  logic [IniAddrWidth-1:0] meta_ini_q;
  logic [BankAddrWidth-1:0] amo_addr_q;
  logic [DataWidth-1:0]    amo_opnd_q;
  logic                    res_valid_q;
  logic [BankAddrWidth-1:0] res_addr_q;
  logic [CoreIdWidth-1:0]  res_core_q;
  logic [IniAddrWidth-1:0] res_ini_q;
  resp_t                   fifo_q [RespDepth];
  logic [PtrWidth-1:0]     rptr_q, wptr_q;
  logic [CntWidth-1:0]     cnt_q, cnt_d;

  logic is_lr, is_sc, is_amo, is_wr, accept, sc_ok;
  logic push, push_bypass, out_valid, pop, deq, store;
  logic [DataWidth-1:0] push_data;
  resp_t push_ent, out_ent;

  assign is_lr  = (req_amo_i == 4'hA);
  assign is_sc  = (req_amo_i == 4'hB);
  assign is_amo = (req_amo_i >= 4'h1) && (req_amo_i <= 4'h9);
  assign is_wr  = req_wen_i && !is_lr && !is_sc && !is_amo;

  // Outstanding reads are counted so every accepted request has a free slot
  // waiting for it; this keeps ready independent of resp_ready_i.
  assign req_ready_o = !rst_i && (state_q == IDLE) &&
                       ((32'(cnt_q) + 32'(pend_q)) < RespDepth);
  assign accept = req_valid_i && req_ready_o;
  assign sc_ok  = is_sc && res_valid_q && (res_addr_q == req_addr_i) &&
                  (res_core_q == req_core_id_i) && (res_ini_q == req_ini_addr_i);

  function automatic logic [DataWidth-1:0] amo_alu(input logic [3:0] opc,
                                                   input logic [DataWidth-1:0] old,
                                                   input logic [DataWidth-1:0] opnd);
    case (opc)
      4'h1:    amo_alu = opnd;
      4'h2:    amo_alu = old + opnd;
      4'h3:    amo_alu = old & opnd;
      4'h4:    amo_alu = old | opnd;
      4'h5:    amo_alu = old ^ opnd;
      4'h6:    amo_alu = ($signed(old) > $signed(opnd)) ? old : opnd;
      4'h7:    amo_alu = (old > opnd) ? old : opnd;
      4'h8:    amo_alu = ($signed(old) < $signed(opnd)) ? old : opnd;
      4'h9:    amo_alu = (old < opnd) ? old : opnd;
      default: amo_alu = old;
    endcase
  endfunction

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    ptr_inc = (p == PtrWidth'(RespDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    state_d     = state_q;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    push        = 1'b0;
    push_bypass = 1'b0;
    push_data   = '0;
    if (!rst_i) begin
      if (state_q == AMO_WB) begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = amo_addr_q;
        mem_be_o    = '1;
        mem_wdata_o = amo_alu(meta_amo_q, mem_rdata_i, amo_opnd_q);
        // Old value goes into storage only, so it appears the cycle after write-back.
        push        = 1'b1;
        push_data   = mem_rdata_i;
        state_d     = IDLE;
      end else if (accept) begin
        mem_req_o   = !is_sc || sc_ok;
        mem_we_o    = is_wr || sc_ok;
        mem_addr_o  = req_addr_i;
        mem_be_o    = req_be_i;
        mem_wdata_o = req_data_i;
        if (is_amo) state_d = AMO_WB;
      end
      if (pend_q) begin
        push        = 1'b1;
        push_bypass = 1'b1;
        push_data   = pend_sc_q ? DataWidth'(pend_sc_fail_q) : mem_rdata_i;
      end
    end
  end

  always_comb begin
    push_ent = '{data: push_data, amo: meta_amo_q, meta_id: meta_id_q,
                 core_id: meta_core_q, ini_addr: meta_ini_q};
    if (cnt_q != '0) begin
      out_valid = 1'b1;
      out_ent   = fifo_q[rptr_q];
    end else begin
      out_valid = push && push_bypass;
      out_ent   = push_ent;
    end
    pop   = out_valid && resp_ready_i && !rst_i;
    deq   = pop && (cnt_q != '0);
    // A bypassed push popped straight through an empty buffer is never stored.
    store = push && !(cnt_q == '0 && pop);
    cnt_d = cnt_q + CntWidth'(store) - CntWidth'(deq);
  end

  assign resp_valid_o    = out_valid && !rst_i;
  assign resp_data_o     = resp_valid_o ? out_ent.data     : '0;
  assign resp_amo_o      = resp_valid_o ? out_ent.amo      : '0;
  assign resp_meta_id_o  = resp_valid_o ? out_ent.meta_id  : '0;
  assign resp_core_id_o  = resp_valid_o ? out_ent.core_id  : '0;
  assign resp_ini_addr_o = resp_valid_o ? out_ent.ini_addr : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      pend_q         <= 1'b0;
      pend_sc_q      <= 1'b0;
      pend_sc_fail_q <= 1'b0;
      meta_amo_q     <= '0;
      meta_id_q      <= '0;
      meta_core_q    <= '0;
      meta_ini_q     <= '0;
      amo_addr_q     <= '0;
      amo_opnd_q     <= '0;
      res_valid_q    <= 1'b0;
      res_addr_q     <= '0;
      res_core_q     <= '0;
      res_ini_q      <= '0;
      rptr_q         <= '0;
      wptr_q         <= '0;
      cnt_q          <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= accept && !is_wr && !is_amo;
      if (accept) begin
        pend_sc_q      <= is_sc;
        pend_sc_fail_q <= !sc_ok;
        meta_amo_q     <= req_amo_i;
        meta_id_q      <= req_meta_id_i;
        meta_core_q    <= req_core_id_i;
        meta_ini_q     <= req_ini_addr_i;
        amo_addr_q     <= req_addr_i;
        amo_opnd_q     <= req_data_i;
        if (is_sc) begin
          res_valid_q <= 1'b0;
        end else if (is_wr && res_valid_q && (req_addr_i == res_addr_q)) begin
          res_valid_q <= 1'b0;
        end
        if (is_lr && LrScEnable) begin
          res_valid_q <= 1'b1;
          res_addr_q  <= req_addr_i;
          res_core_q  <= req_core_id_i;
          res_ini_q   <= req_ini_addr_i;
        end
      end else if (state_q == AMO_WB && res_valid_q && (amo_addr_q == res_addr_q)) begin
        res_valid_q <= 1'b0;
      end
      if (store) wptr_q <= ptr_inc(wptr_q);
      if (deq)   rptr_q <= ptr_inc(rptr_q);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (store) fifo_q[wptr_q] <= push_ent;
  end

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// tb/tb_tcdm_bank_responder.sv - self-checking bench for tcdm_bank_responder
module tb_tcdm_bank_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_addr = '0;
  logic        req_wen = 1'b0;
  logic [3:0]  req_be = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_amo = '0;
  logic [5:0]  req_meta = '0;
  logic [1:0]  req_core = '0;
  logic [3:0]  req_ini = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_data;
  logic [3:0]  resp_amo;
  logic [5:0]  resp_meta;
  logic [1:0]  resp_core;
  logic [3:0]  resp_ini;
  logic        mem_req, mem_we;
  logic [7:0]  mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] sram [256];
  int          wr_count = 0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  tcdm_bank_responder dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_wen_i(req_wen), .req_be_i(req_be), .req_data_i(req_data), .req_amo_i(req_amo),
    .req_meta_id_i(req_meta), .req_core_id_i(req_core), .req_ini_addr_i(req_ini),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_data_o(resp_data),
    .resp_amo_o(resp_amo), .resp_meta_id_o(resp_meta), .resp_core_id_o(resp_core),
    .resp_ini_addr_o(resp_ini),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_be_o(mem_be),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  // Behavioural single-port SRAM with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_req) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        wr_count <= wr_count + 1;
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  typedef struct packed {
    logic [7:0]  addr;
    logic        wen;
    logic [3:0]  be;
    logic [31:0] data;
    logic [3:0]  amo;
    logic [5:0]  meta;
    logic [1:0]  core;
    logic [3:0]  ini;
    logic [2:0]  lat;    // 0: no response expected
    logic [31:0] rdata;
    logic [1:0]  wr;     // SRAM writes expected
  } vec_t;

  function automatic vec_t mk(input logic [7:0] a, input logic w, input logic [3:0] be,
                              input logic [31:0] d, input logic [3:0] amo,
                              input logic [5:0] m, input logic [1:0] c, input logic [3:0] i,
                              input logic [2:0] lat, input logic [31:0] rd, input logic [1:0] wr);
    mk = '{addr: a, wen: w, be: be, data: d, amo: amo, meta: m, core: c, ini: i,
           lat: lat, rdata: rd, wr: wr};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    req_addr = v.addr; req_wen = v.wen; req_be = v.be; req_data = v.data;
    req_amo = v.amo; req_meta = v.meta; req_core = v.core; req_ini = v.ini;
    req_valid = 1'b1;
  endtask

  task automatic issue(input vec_t v, input string tag);
    int n, lat, w0;
    logic [31:0] d;
    logic [3:0] a, ini;
    logic [5:0] m;
    logic [1:0] c;
    @(negedge clk);
    drive(v);
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk({tag, "_accept_timeout"}, 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    w0 = wr_count;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; d = '0; a = '0; m = '0; c = '0; ini = '0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (resp_valid && lat == 0) begin
        lat = k; d = resp_data; a = resp_amo; m = resp_meta; c = resp_core; ini = resp_ini;
      end
    end
    chk({tag, "_latency"}, 32'(lat), 32'(v.lat));
    if (v.lat != 0) begin
      chk({tag, "_data"}, d, v.rdata);
      chk({tag, "_meta"}, 32'(m), 32'(v.meta));
      chk({tag, "_core"}, 32'(c), 32'(v.core));
      chk({tag, "_ini"}, 32'(ini), 32'(v.ini));
      chk({tag, "_amo"}, 32'(a), 32'(v.amo));
    end
    chk({tag, "_writes"}, 32'(wr_count - w0), 32'(v.wr));
  endtask

  localparam int NV = 34;
  vec_t vecs [NV];
  int   acc;
  bit   rdy;
  int   got;
  logic [5:0]  got_meta [4];
  logic [31:0] got_data [4];
  int   w0;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    //                addr  wen be    data          amo   meta  core ini lat rdata        wr
    vecs[0]  = mk(8'd5, 1, 4'hF, 32'hDEADBEEF, 4'h0, 6'd1,  2'd0, 4'd0, 0, 32'h0,        1);
    vecs[1]  = mk(8'd5, 0, 4'hF, 32'h0,        4'h0, 6'd3,  2'd0, 4'd2, 1, 32'hDEADBEEF, 0);
    vecs[2]  = mk(8'd7, 1, 4'hF, 32'd10,       4'h0, 6'd2,  2'd0, 4'd0, 0, 32'h0,        1);
    vecs[3]  = mk(8'd7, 0, 4'hF, 32'd5,        4'h2, 6'd4,  2'd1, 4'd1, 2, 32'd10,       1);
    vecs[4]  = mk(8'd7, 0, 4'hF, 32'h0,        4'h0, 6'd5,  2'd0, 4'd3, 1, 32'd15,       0);
    vecs[5]  = mk(8'd9, 1, 4'hF, 32'hFFFFFFFF, 4'h0, 6'd0,  2'd0, 4'd0, 0, 32'h0,        1);
    vecs[6]  = mk(8'd9, 0, 4'hF, 32'd1,        4'h6, 6'd6,  2'd0, 4'd0, 2, 32'hFFFFFFFF, 1);
    vecs[7]  = mk(8'd9, 0, 4'hF, 32'h0,        4'h0, 6'd7,  2'd0, 4'd0, 1, 32'd1,        0);
    vecs[8]  = mk(8'd9, 1, 4'hF, 32'hFFFFFFFF, 4'h0, 6'd0,  2'd0, 4'd0, 0, 32'h0,        1);
    vecs[9]  = mk(8'd9, 0, 4'hF, 32'd1,        4'h7, 6'd8,  2'd2, 4'd5, 2, 32'hFFFFFFFF, 1);
    vecs[10] = mk(8'd9, 0, 4'hF, 32'h0,        4'h0, 6'd9,  2'd0, 4'd0, 1, 32'hFFFFFFFF, 0);
    vecs[11] = mk(8'd4, 1, 4'hF, 32'h0,        4'h0, 6'd0,  2'd0, 4'd0, 0, 32'h0,        1);
    vecs[12] = mk(8'd4, 0, 4'hF, 32'h0,        4'hA, 6'd10, 2'd1, 4'd0, 1, 32'h0,        0);
    vecs[13] = mk(8'd4, 0, 4'hF, 32'h12345678, 4'hB, 6'd11, 2'd1, 4'd0, 1, 32'h0,        1);
    vecs[14] = mk(8'd4, 0, 4'hF, 32'h0,        4'h0, 6'd12, 2'd0, 4'd0, 1, 32'h12345678, 0);
    vecs[15] = mk(8'd4, 0, 4'hF, 32'h0,        4'hA, 6'd13, 2'd1, 4'd0, 1, 32'h12345678, 0);
    vecs[16] = mk(8'd4, 1, 4'hC, 32'hAAAA0000, 4'h0, 6'd0,  2'd1, 4'd0, 0, 32'h0,        1);
    vecs[17] = mk(8'd4, 0, 4'hF, 32'h11111111, 4'hB, 6'd14, 2'd1, 4'd0, 1, 32'd1,        0);
    vecs[18] = mk(8'd4, 0, 4'hF, 32'h0,        4'h0, 6'd15, 2'd0, 4'd0, 1, 32'hAAAA5678, 0);
    vecs[19] = mk(8'd2, 1, 4'hF, 32'h0000FFFF, 4'h0, 6'd0,  2'd0, 4'd0, 0, 32'h0,        1);
    vecs[20] = mk(8'd2, 0, 4'hF, 32'h00FF00FF, 4'h3, 6'd16, 2'd0, 4'd0, 2, 32'h0000FFFF, 1);
    vecs[21] = mk(8'd2, 0, 4'hF, 32'h00000010, 4'h9, 6'd17, 2'd0, 4'd0, 2, 32'h000000FF, 1);
    vecs[22] = mk(8'd2, 0, 4'hF, 32'h00000018, 4'h5, 6'd18, 2'd0, 4'd0, 2, 32'h00000010, 1);
    vecs[23] = mk(8'd2, 0, 4'hF, 32'h0000CAFE, 4'h1, 6'd19, 2'd0, 4'd0, 2, 32'h00000008, 1);
    vecs[24] = mk(8'd2, 0, 4'hF, 32'h0,        4'hC, 6'd20, 2'd3, 4'd7, 1, 32'h0000CAFE, 0);
    vecs[25] = mk(8'd4, 0, 4'hF, 32'h0,        4'hA, 6'd21, 2'd1, 4'd0, 1, 32'hAAAA5678, 0);
    vecs[26] = mk(8'd4, 0, 4'hF, 32'h0,        4'hB, 6'd22, 2'd2, 4'd0, 1, 32'd1,        0);
    vecs[27] = mk(8'd4, 0, 4'hF, 32'h0,        4'hB, 6'd23, 2'd1, 4'd0, 1, 32'd1,        0);
    vecs[28] = mk(8'd2, 0, 4'hF, 32'h00000001, 4'h4, 6'd24, 2'd0, 4'd0, 2, 32'h0000CAFE, 1);
    vecs[29] = mk(8'd2, 0, 4'hF, 32'h0,        4'h0, 6'd25, 2'd0, 4'd0, 1, 32'h0000CAFF, 0);
    vecs[30] = mk(8'd3, 1, 4'hF, 32'd5,        4'h0, 6'd0,  2'd0, 4'd0, 0, 32'h0,        1);
    vecs[31] = mk(8'd3, 0, 4'hF, 32'hFFFFFFFE, 4'h8, 6'd26, 2'd0, 4'd0, 2, 32'd5,        1);
    vecs[32] = mk(8'd3, 0, 4'hF, 32'h0,        4'h0, 6'd27, 2'd0, 4'd0, 1, 32'hFFFFFFFE, 0);
    vecs[33] = mk(8'd7, 0, 4'hF, 32'h0,        4'hF, 6'd28, 2'd0, 4'd9, 1, 32'd15,       0);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);
    chk("post_rst_resp_valid", 32'(resp_valid), 32'd0);

    for (int i = 0; i < NV; i++) issue(vecs[i], $sformatf("vec%0d", i));

    // AMO: ready low for exactly the write-back cycle, response one cycle later
    @(negedge clk);
    drive(mk(8'd7, 0, 4'hF, 32'd5, 4'h2, 6'd30, 2'd0, 4'd0, 0, 32'h0, 0));
    chk("amo_ready_before", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("amo_ready_wb", 32'(req_ready), 32'd0);
    chk("amo_resp_wb", 32'(resp_valid), 32'd0);
    chk("amo_mem_we_wb", 32'(mem_we), 32'd1);
    chk("amo_mem_wdata_wb", mem_wdata, 32'd20);
    @(negedge clk);
    chk("amo_ready_after", 32'(req_ready), 32'd1);
    chk("amo_resp_valid", 32'(resp_valid), 32'd1);
    chk("amo_resp_data", resp_data, 32'd15);
    @(negedge clk);
    chk("amo_resp_popped", 32'(resp_valid), 32'd0);

    // Backpressure: two reads fit, then ready drops while responses hold
    resp_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (acc < 4) drive(mk((acc < 2) ? 8'd5 : 8'd2, 0, 4'hF, 32'h0, 4'h0, 6'(40 + acc),
                            2'd0, 4'(acc), 0, 32'h0, 0));
      rdy = req_ready;
      @(posedge clk);
      if (rdy) acc++;
    end
    @(negedge clk);
    chk("bp_accepted", 32'(acc), 32'd2);
    chk("bp_req_ready", 32'(req_ready), 32'd0);
    chk("bp_resp_valid", 32'(resp_valid), 32'd1);
    chk("bp_hold_meta", 32'(resp_meta), 32'd40);
    chk("bp_hold_data", resp_data, 32'hDEADBEEF);
    resp_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 30 && got < 4; c++) begin
      if (c != 0) @(negedge clk);
      if (resp_valid) begin
        got_meta[got] = resp_meta;
        got_data[got] = resp_data;
        got++;
      end
      if (acc < 4) drive(mk(8'd2, 0, 4'hF, 32'h0, 4'h0, 6'(40 + acc), 2'd0, 4'(acc), 0, 32'h0, 0));
      else req_valid = 1'b0;
      rdy = req_ready && (acc < 4);
      @(posedge clk);
      if (rdy) acc++;
    end
    req_valid = 1'b0;
    chk("bp_resp_count", 32'(got), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < got) begin
        chk($sformatf("bp_meta%0d", k), 32'(got_meta[k]), 32'(40 + k));
        chk($sformatf("bp_data%0d", k), got_data[k], (k < 2) ? 32'hDEADBEEF : 32'h0000CAFF);
      end
    end

    // Reset during AMO write-back
    issue(mk(8'd4, 0, 4'hF, 32'h0, 4'hA, 6'd50, 2'd1, 4'd0, 1, 32'hAAAA5678, 0), "rs_lr");
    @(negedge clk);
    drive(mk(8'd7, 0, 4'hF, 32'd100, 4'h2, 6'd51, 2'd0, 4'd0, 0, 32'h0, 0));
    @(posedge clk);
    #1 req_valid = 1'b0;
    rst = 1'b1;
    w0 = wr_count;
    @(negedge clk);
    chk("rs_mem_req_wb", 32'(mem_req), 32'd0);
    @(negedge clk);
    chk("rs_resp_valid", 32'(resp_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rs_no_writeback", 32'(wr_count - w0), 32'd0);
    chk("rs_resp_valid_after", 32'(resp_valid), 32'd0);
    chk("rs_req_ready_after", 32'(req_ready), 32'd1);
    issue(mk(8'd4, 0, 4'hF, 32'h55555555, 4'hB, 6'd52, 2'd1, 4'd0, 1, 32'd1, 0), "rs_sc");
    issue(mk(8'd7, 0, 4'hF, 32'h0, 4'h0, 6'd53, 2'd0, 4'd0, 1, 32'd20, 0), "rs_read7");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
